// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: NUM_CH independent one-cycle strobes,
// each with its own period, periodic/one-shot mode and start/stop, plus a global pause.
`timescale 1ns/1ps
module tick_gen_multi #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 650000,
  parameter bit          AUTO_RUN       = 1'b1,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              pause,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);

  genvar gi;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] period_reg, period_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             oneshot_reg, oneshot_next;
      logic             run_reg, run_next;
      logic             tick_reg, tick_next;
      logic             wr_sel;

      // Out-of-range channel indices match no channel, so such writes are dropped.
      assign wr_sel = cfg_we && (cfg_ch == CH_W'(gi));

      always_comb begin
        period_next  = period_reg;
        oneshot_next = oneshot_reg;
        cnt_next     = cnt_reg;
        run_next     = run_reg;
        tick_next    = 1'b0;

        if (wr_sel) begin
          period_next  = cfg_period;
          oneshot_next = cfg_oneshot;
        end

        // The compare uses the period held before this edge; a write lands for the next one.
        if (stop[gi]) begin
          run_next = 1'b0;
          cnt_next = '0;
        end else if (start[gi]) begin
          run_next = 1'b1;
          cnt_next = '0;
        end else if (run_reg && !pause) begin
          if (cnt_reg >= period_reg) begin
            tick_next = 1'b1;
            cnt_next  = '0;
            if (oneshot_reg) begin
              run_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          period_reg  <= CNT_W'(DEFAULT_PERIOD);
          oneshot_reg <= 1'b0;
          cnt_reg     <= '0;
          run_reg     <= AUTO_RUN;
          tick_reg    <= 1'b0;
        end else begin
          period_reg  <= period_next;
          oneshot_reg <= oneshot_next;
          cnt_reg     <= cnt_next;
          run_reg     <= run_next;
          tick_reg    <= tick_next;
        end
      end

      assign tick[gi]    = tick_reg;
      assign running[gi] = run_reg;
    end
  endgenerate

endmodule
